// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared definitions for the IF/MEM memory port arbiter.
//               Provides the 2-bit arbiter FSM state encoding and the data
//               word returned to a requester whose transaction timed out.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,  // no transaction outstanding
        ST_FETCH = 2'd1,  // serving the instruction-fetch port
        ST_DATA  = 2'd2,  // serving the data-memory port
        ST_DRAIN = 2'd3   // flushed fetch still in flight, data discarded
    } arb_state_t;

    localparam logic [31:0] ARB_ERR_WORD = 32'hDEADBEEF;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. Clear has
//               priority over increment; the count sticks at all-ones.
// Ports       : clk   - clock
//               clr   - synchronous clear, active-high
//               inc   - increment enable
//               cnt_o - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt_o
);

    localparam logic [WIDTH-1:0] c_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != c_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates instruction fetch (IF) and data access (MEM) onto
//               one single-ported, variable-latency memory. DATA has priority
//               in IDLE. A flushed fetch drains its in-flight access and
//               discards the data. A busy-cycle watchdog aborts hung accesses,
//               sets a sticky err and returns ARB_ERR_WORD to the owner.
// Config      : MEM_ARB_STATS_EN - adds stat_conflict / stat_busy counters.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               if_*                - fetch request/response, flush redirect
//               dm_*                - data request/response
//               ram_*               - shared memory port
//               err                 - sticky timeout flag
//               stat_conflict/busy  - optional statistics counters
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ack,
    output logic                  if_stall,
    input  logic                  flush,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_ack,
    output logic                  dm_stall,
    output logic                  ram_cs,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    input  logic                  ram_ack,
    output logic                  err
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           stat_conflict,
    output logic [15:0]           stat_busy
`endif
);

    // Busy counter value on the last permitted busy cycle: with a count of 0
    // in the first busy cycle, the memory gets exactly TIMEOUT_CYCLES cycles.
    localparam logic [7:0]            c_BUSY_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_ERR_DATA  = DATA_WIDTH'(ARB_ERR_WORD);

    arb_state_t            state_q,     state_d;
    logic                  ram_cs_q,    ram_cs_d;
    logic                  ram_we_q,    ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                  if_ack_q,    if_ack_d;
    logic                  dm_ack_q,    dm_ack_d;
    logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q,  dm_rdata_d;
    logic                  err_q,       err_d;
    logic [7:0]            busy_q,      busy_d;

    // A requester whose ack is showing this cycle still holds its request
    // from the transaction just completed, so it must not be re-granted.
    logic w_dm_elig;
    logic w_if_elig;
    logic w_timeout;

    assign w_dm_elig = dm_req & ~dm_ack_q;
    assign w_if_elig = if_req & ~if_ack_q & ~flush;
    assign w_timeout = (busy_q == c_BUSY_LAST);

    always_comb begin
        state_d     = state_q;
        ram_cs_d    = ram_cs_q;
        ram_we_d    = ram_we_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (w_dm_elig) begin
                    state_d     = ST_DATA;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = dm_we;
                    ram_addr_d  = dm_addr;
                    ram_wdata_d = dm_wdata;
                    busy_d      = 8'd0;
                end else if (w_if_elig) begin
                    state_d     = ST_FETCH;
                    ram_cs_d    = 1'b1;
                    ram_we_d    = 1'b0;
                    ram_addr_d  = if_addr;
                    ram_wdata_d = '0;
                    busy_d      = 8'd0;
                end
            end

            ST_FETCH: begin
                if (ram_ack) begin
                    state_d  = ST_IDLE;
                    ram_cs_d = 1'b0;
                    // A flush landing with the ack cancels the fetch outright.
                    if (!flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = ram_rdata;
                    end
                end else if (w_timeout) begin
                    state_d  = ST_IDLE;
                    ram_cs_d = 1'b0;
                    err_d    = 1'b1;
                    if (!flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = c_ERR_DATA;
                    end
                end else begin
                    busy_d = busy_q + 8'd1;
                    if (flush) begin
                        state_d = ST_DRAIN;
                    end
                end
            end

            ST_DATA: begin
                if (ram_ack) begin
                    state_d    = ST_IDLE;
                    ram_cs_d   = 1'b0;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = ram_rdata;
                end else if (w_timeout) begin
                    state_d    = ST_IDLE;
                    ram_cs_d   = 1'b0;
                    err_d      = 1'b1;
                    dm_ack_d   = 1'b1;
                    dm_rdata_d = c_ERR_DATA;
                end else begin
                    busy_d = busy_q + 8'd1;
                end
            end

            ST_DRAIN: begin
                if (ram_ack) begin
                    state_d  = ST_IDLE;
                    ram_cs_d = 1'b0;
                end else if (w_timeout) begin
                    state_d  = ST_IDLE;
                    ram_cs_d = 1'b0;
                    err_d    = 1'b1;
                end else begin
                    busy_d = busy_q + 8'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                ram_cs_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ram_cs_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
            busy_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            ram_cs_q    <= ram_cs_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
        end
    end

    assign ram_cs    = ram_cs_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign if_ack    = if_ack_q;
    assign dm_ack    = dm_ack_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign err       = err_q;
    assign if_stall  = if_req & ~if_ack_q;
    assign dm_stall  = dm_req & ~dm_ack_q;

`ifdef MEM_ARB_STATS_EN
    logic w_conflict;

    assign w_conflict = (state_q == ST_IDLE) & w_dm_elig & w_if_elig;

    sat_counter #(.WIDTH(16)) u_stat_conflict (
        .clk   (clk),
        .clr   (rst),
        .inc   (w_conflict),
        .cnt_o (stat_conflict)
    );

    sat_counter #(.WIDTH(16)) u_stat_busy (
        .clk   (clk),
        .clr   (rst),
        .inc   (ram_cs_q),
        .cnt_o (stat_busy)
    );
`endif

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter with
//               TIMEOUT_CYCLES = 4. Covers reset state, a 4-cycle load,
//               simultaneous requests, flush-to-drain, flush coinciding with
//               ram_ack, store timeout and reset mid-transaction.
//               Honors MEM_ARB_STATS_EN for the optional counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ack;
    logic          if_stall;
    logic          flush;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic          dm_stall;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          ram_ack;
    logic          err;
`ifdef MEM_ARB_STATS_EN
    logic [15:0]   stat_conflict;
    logic [15:0]   stat_busy;
`endif

    int vectors = 0;
    int fails   = 0;

    mem_port_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ack    (if_ack),
        .if_stall  (if_stall),
        .flush     (flush),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_ack    (dm_ack),
        .dm_stall  (dm_stall),
        .ram_cs    (ram_cs),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .err       (err)
`ifdef MEM_ARB_STATS_EN
        ,
        .stat_conflict (stat_conflict),
        .stat_busy     (stat_busy)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        ram_rdata = '0; ram_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // ---- reset state
        check("rst_cs",      32'(ram_cs),   32'd0);
        check("rst_we",      32'(ram_we),   32'd0);
        check("rst_if_ack",  32'(if_ack),   32'd0);
        check("rst_dm_ack",  32'(dm_ack),   32'd0);
        check("rst_err",     32'(err),      32'd0);
        check("rst_addr",    ram_addr,      32'd0);
        check("rst_wdata",   ram_wdata,     32'd0);
        check("rst_if_rd",   if_rdata,      32'd0);
        check("rst_dm_rd",   dm_rdata,      32'd0);

        // ---- single load, ram_ack on the 4th cs cycle
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0100;
        tick();
        check("ld_stall", 32'(dm_stall), 32'd1);
        check("ld_we",    32'(ram_we),   32'd0);
        for (int i = 0; i < 3; i++) begin
            check("ld_cs",    32'(ram_cs), 32'd1);
            check("ld_addr",  ram_addr,    32'h0000_0100);
            check("ld_noack", 32'(dm_ack), 32'd0);
            tick();
        end
        check("ld_cs4", 32'(ram_cs), 32'd1);
        ram_ack = 1'b1; ram_rdata = 32'hCAFE_0001;
        tick();
        check("ld_ack",      32'(dm_ack),   32'd1);
        check("ld_rdata",    dm_rdata,      32'hCAFE_0001);
        check("ld_cs_drop",  32'(ram_cs),   32'd0);
        check("ld_stall_lo", 32'(dm_stall), 32'd0);
        ram_ack = 1'b0; dm_req = 1'b0;
        tick();
        check("ld_ack_once", 32'(dm_ack), 32'd0);
        check("ld_cs_idle",  32'(ram_cs), 32'd0);
        check("ld_hold",     dm_rdata,    32'hCAFE_0001);

        // ---- simultaneous IF + MEM: store first, then fetch
        if_req = 1'b1; if_addr = 32'h0000_0200;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0300;
        dm_wdata = 32'h1234_5678;
        tick();
        check("co_cs",    32'(ram_cs),   32'd1);
        check("co_we",    32'(ram_we),   32'd1);
        check("co_addr",  ram_addr,      32'h0000_0300);
        check("co_wdata", ram_wdata,     32'h1234_5678);
        check("co_ifst",  32'(if_stall), 32'd1);
        ram_ack = 1'b1; ram_rdata = 32'h5555_AAAA;
        tick();
        check("co_dm_ack", 32'(dm_ack), 32'd1);
        check("co_dm_rd",  dm_rdata,    32'h5555_AAAA);
        check("co_if_no",  32'(if_ack), 32'd0);
        check("co_cs_lo",  32'(ram_cs), 32'd0);
        ram_ack = 1'b0; dm_req = 1'b0;
        tick();
        check("co_f_cs",   32'(ram_cs), 32'd1);
        check("co_f_addr", ram_addr,    32'h0000_0200);
        check("co_f_we",   32'(ram_we), 32'd0);
        check("co_dm_lo",  32'(dm_ack), 32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h0BAD_F00D;
        tick();
        check("co_if_ack", 32'(if_ack), 32'd1);
        check("co_if_rd",  if_rdata,    32'h0BAD_F00D);
        ram_ack = 1'b0; if_req = 1'b0;
        tick();
        check("co_if_lo",  32'(if_ack), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check("st_conflict", 32'(stat_conflict), 32'd1);
        check("st_busy",     32'(stat_busy),     32'd6);
`endif

        // ---- flush one cycle into a fetch, ram_ack two cycles later
        if_req = 1'b1; if_addr = 32'h0000_0400;
        tick();
        check("fl_cs", 32'(ram_cs), 32'd1);
        tick();
        flush = 1'b1; if_req = 1'b0;
        tick();
        flush = 1'b0;
        check("fl_drain_cs", 32'(ram_cs), 32'd1);
        check("fl_noack1",   32'(if_ack), 32'd0);
        check("fl_addr",     ram_addr,    32'h0000_0400);
        tick();
        ram_ack = 1'b1; ram_rdata = 32'h1111_1111;
        tick();
        ram_ack = 1'b0;
        check("fl_cs_lo",  32'(ram_cs), 32'd0);
        check("fl_noack2", 32'(if_ack), 32'd0);
        check("fl_keep",   if_rdata,    32'h0BAD_F00D);
        tick();
        check("fl_noack3", 32'(if_ack), 32'd0);

        // ---- flush coinciding with ram_ack in FETCH
        if_req = 1'b1; if_addr = 32'h0000_0500;
        tick();
        check("fa_cs", 32'(ram_cs), 32'd1);
        flush = 1'b1; if_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h2222_2222;
        tick();
        flush = 1'b0; ram_ack = 1'b0;
        check("fa_noack", 32'(if_ack), 32'd0);
        check("fa_cs_lo", 32'(ram_cs), 32'd0);
        check("fa_keep",  if_rdata,    32'h0BAD_F00D);

        // ---- store with no ram_ack: timeout after 4 busy cycles.
        // Grant on the very next edge also proves the FSM is back in IDLE.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0600;
        dm_wdata = 32'hA5A5_A5A5;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("to_cs",    32'(ram_cs), 32'd1);
            check("to_noack", 32'(dm_ack), 32'd0);
            check("to_noerr", 32'(err),    32'd0);
            tick();
        end
        check("to_cs_lo", 32'(ram_cs), 32'd0);
        check("to_ack",   32'(dm_ack), 32'd1);
        check("to_rdata", dm_rdata,    32'hDEAD_BEEF);
        check("to_err",   32'(err),    32'd1);
        dm_req = 1'b0;
        tick();
        tick();
        check("to_ack_lo",  32'(dm_ack), 32'd0);
        check("to_err_stk", 32'(err),    32'd1);

        // ---- reset while in DATA
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0700;
        dm_wdata = 32'h0000_0077;
        tick();
        check("rd_cs", 32'(ram_cs), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0; dm_req = 1'b0;
        check("rd_cs0",    32'(ram_cs), 32'd0);
        check("rd_we0",    32'(ram_we), 32'd0);
        check("rd_addr0",  ram_addr,    32'd0);
        check("rd_wdata0", ram_wdata,   32'd0);
        check("rd_ack0",   32'(dm_ack), 32'd0);
        check("rd_err0",   32'(err),    32'd0);
        check("rd_dmrd0",  dm_rdata,    32'd0);
        check("rd_ifrd0",  if_rdata,    32'd0);
        ram_ack = 1'b1; ram_rdata = 32'h9999_9999;
        tick();
        ram_ack = 1'b0;
        check("rd_late_ack", 32'(dm_ack), 32'd0);
        check("rd_late_rd",  dm_rdata,    32'd0);
        check("rd_late_cs",  32'(ram_cs), 32'd0);
`ifdef MEM_ARB_STATS_EN
        check("st_conf_clr", 32'(stat_conflict), 32'd0);
        check("st_busy_clr", 32'(stat_busy),     32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule : tb_mem_port_arbiter
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the MIPS 5-stage pipeline's instruction fetch (IF) and data access (MEM) onto one shared single-ported memory with variable latency. It sequences each transaction through a small FSM and handles branch flushes of in-flight fetches. It also guards against a hung memory with a timeout. Its `if_stall`/`dm_stall` outputs feed the pipeline controller's stage-enable logic.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, data word width
- `TIMEOUT_CYCLES`, 64, maximum busy cycles before abort; legal range 2..255
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `if_req`  in  1  fetch request; held until `if_ack` or dropped by `flush`
- `if_addr`  in  ADDR_WIDTH  fetch address
- `if_rdata`  out  DATA_WIDTH  fetched word; valid while `if_ack`
- `if_ack`  out  1  one-cycle fetch completion pulse
- `if_stall`  out  1  `if_req & ~if_ack`
- `flush`  in  1  branch/jump redirect; cancels the current fetch
- `dm_req`  in  1  data request; held until `dm_ack`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  ADDR_WIDTH  data address
- `dm_wdata`  in  DATA_WIDTH  store data
- `dm_rdata`  out  DATA_WIDTH  load data; valid while `dm_ack`
- `dm_ack`  out  1  one-cycle data completion pulse
- `dm_stall`  out  1  `dm_req & ~dm_ack`
- `ram_cs`  out  1  memory select; held for the whole transaction
- `ram_we`, `ram_addr`, `ram_wdata`  out  1/ADDR_WIDTH/DATA_WIDTH  latched at grant, stable while `ram_cs`
- `ram_rdata`  in  DATA_WIDTH  memory read data; sampled at `ram_ack`
- `ram_ack`  in  1  memory completion pulse; ignored when `ram_cs`=0
- `err`  out  1  sticky timeout flag

## Operation
- FSM states:
  - IDLE: no transaction.
  - FETCH: serving IF.
  - DATA: serving MEM.
  - DRAIN: a flushed fetch is still in flight; its data is discarded.
- IDLE grant rules:
  - Priority goes to DATA if `dm_req` is high and `dm_ack` is low.
  - Otherwise FETCH if `if_req` is high and both `if_ack` and `flush` are low.
  - In either case, `we`, `addr` and `wdata` are latched into the `ram_*` registers on the grant.
- A requester whose ack is high in the current cycle is not eligible for grant, because its request is still high from the completed transaction.
- FETCH or DATA with `ram_ack`:
  - Latch `ram_rdata` into the granted requester's `rdata`.
  - Pulse that requester's ack on the next cycle.
  - Return to IDLE.
- FETCH with `flush` and no `ram_ack`: go to DRAIN.
- FETCH with `flush` and `ram_ack` in the same cycle: go to IDLE with no `if_ack`.
- DRAIN: hold `ram_cs` until `ram_ack`, discard the data, then go to IDLE. `flush` in DRAIN has no additional effect.
- `flush` during DATA has no effect.
- Timeout:
  - A busy counter resets on each grant.
  - When it reaches TIMEOUT_CYCLES without `ram_ack`: set `err`, go to IDLE, deassert `ram_cs`.
  - In FETCH or DATA, also ack the owner with `rdata` = 32'hDEADBEEF. In DRAIN, ack no one.
- `rdata` holds its last value between acks. Loads and stores are identical apart from `ram_we`.

## Timing
- Reset values: state IDLE; `ram_cs`, `ram_we`, `if_ack`, `dm_ack`, `err` all 0; `ram_addr`, `ram_wdata`, `if_rdata`, `dm_rdata`, busy counter all 0.
- Request seen in IDLE at cycle t: `ram_cs` is high from t+1.
- `ram_ack` at cycle t+k: requester ack at t+k+1 while the FSM is in IDLE. Minimum latency is 2 cycles (k=1).
- Next grant at the earliest at t+k+1, taking effect at t+k+2.
- `rst` mid-transaction aborts with no ack; a late `ram_ack` after reset is ignored.

## Configuration
- `MEM_ARB_STATS_EN` defined:
  - Adds output `stat_conflict` [15:0]: counts IDLE cycles in which both requests are eligible.
  - Adds output `stat_busy` [15:0]: counts cycles with `ram_cs` high.
  - Both counters saturate at 16'hFFFF and clear on `rst`.
- Undefined: both ports and their counters are absent. Behaviour is otherwise identical.

## Structure
- Package `mem_arb_pkg`: FSM state encoding (IDLE/FETCH/DATA/DRAIN, 2-bit) and the `ARB_ERR_WORD` 32'hDEADBEEF constant.
- Sub-module `sat_counter` (parameterised width, with `inc` and `clr` inputs) is instantiated for each stats counter and is present only under `MEM_ARB_STATS_EN`.

## Test plan
- Single load, `ram_ack` 3 cycles after `ram_cs` rises: `dm_ack` pulses exactly once, 1 cycle later, with `dm_rdata` = `ram_rdata`. `ram_addr` is stable throughout.
- `if_req` and `dm_req` raised together: DATA is granted first. FETCH is granted in the cycle after `dm_ack`, and `if_ack` follows its own `ram_ack`. With `MEM_ARB_STATS_EN`, `stat_conflict` = 1.
- `flush` 1 cycle into a fetch, `ram_ack` 2 cycles later: FSM passes through DRAIN, no `if_ack` is issued, and `ram_cs` drops after the ack.
- `flush` and `ram_ack` in the same FETCH cycle: no `if_ack`, FSM returns to IDLE.
- Store with `ram_ack` never asserted, TIMEOUT_CYCLES=4: `ram_cs` drops after 4 cycles, `dm_ack` pulses with 32'hDEADBEEF, and `err` stays 1 until `rst`.
- `rst` asserted while in DATA: next cycle all outputs are at reset values, no ack is issued, and a following `ram_ack` is ignored.
